// File: rtl/control_fsm.sv
// Multicycle main control unit for the RV32 core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and write enables.
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC+4 into PC when memory is ready
    // DECODE   | read registers, precompute branch target in ALUOut
    // MEMADR   | compute load/store address
    // MEMREAD  | load access, waits on mem_ready
    // MEMWB    | write loaded data to rd
    // MEMWRITE | store access, waits on mem_ready
    // EXECUTER | register-register ALU op
    // EXECUTEI | register-immediate ALU op
    // ALUWB    | write ALUOut to rd
    // JAL      | PC <- target, ALU computes return address
    // BEQ      | compare, PC <- target if zero
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t state;
    state_t state_next;

    logic pc_update;
    logic branch;
    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;
    logic illegal_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
                    OP_JAL:            state_next = JAL;
                    OP_BEQ:            state_next = BEQ;
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            JAL:      state_next = ALUWB;
            BEQ:      state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
            end
            DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                illegal_raw = !(opcode == OP_LOAD || opcode == OP_STORE ||
                                opcode == OP_RTYPE || opcode == OP_ITYPE ||
                                opcode == OP_JAL || opcode == OP_BEQ);
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: begin
                alu_op = 2'b00;
            end
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // Enables are masked by reset directly so an abort is visible before the next edge.
    assign ir_write  = !reset && ir_write_raw;
    assign pc_write  = !reset && (pc_update || (branch && zero));
    assign reg_write = !reset && reg_write_raw;
    assign mem_write = !reset && mem_write_raw;
    assign illegal   = !reset && illegal_raw;

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm; each row is one clock of inputs
// plus the hand-derived outputs expected in that cycle.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;

    control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {alu_op, alu_src_a, alu_src_b, result_src, adr_src}
    localparam logic [8:0] B_FETCH  = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0};
    localparam logic [8:0] B_DECODE = {2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [8:0] B_MEMADR = {2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [8:0] B_MEMRW  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [8:0] B_MEMWB  = {2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [8:0] B_EXR    = {2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [8:0] B_EXI    = {2'b10, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [8:0] B_ALUWB  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [8:0] B_JAL    = {2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [8:0] B_BEQ    = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0};

    // {ir_write, pc_write, reg_write, mem_write, illegal}
    localparam logic [4:0] EN_0   = 5'b00000;
    localparam logic [4:0] EN_FCH = 5'b11000;
    localparam logic [4:0] EN_PC  = 5'b01000;
    localparam logic [4:0] EN_RW  = 5'b00100;
    localparam logic [4:0] EN_MW  = 5'b00010;
    localparam logic [4:0] EN_ILL = 5'b00001;

    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic       z;
        logic       mr;
        logic [8:0] base;
        logic [1:0] imm;
        logic [4:0] en;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    wire [15:0] act = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                       imm_src, ir_write, pc_write, reg_write, mem_write, illegal};

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                       input logic [8:0] b, input logic [1:0] i, input logic [4:0] e,
                       input string n);
        vec_t v;
        v.rst = r; v.opc = o; v.z = z; v.mr = m; v.base = b; v.imm = i; v.en = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b (alu_op,a,b,res,adr,imm,ir,pc,rw,mw,ill)",
                     name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = OP_I; zero = 1'b0; mem_ready = 1'b1;

        add(1, OP_I,   0, 1, B_FETCH,  2'b00, EN_0,   "reset_hold0");
        add(1, OP_I,   0, 1, B_FETCH,  2'b00, EN_0,   "reset_hold1");
        add(0, OP_R,   0, 1, B_FETCH,  2'b00, EN_FCH, "r_fetch");
        add(0, OP_R,   0, 1, B_DECODE, 2'b00, EN_0,   "r_decode");
        add(0, OP_R,   0, 1, B_EXR,    2'b00, EN_0,   "r_executer");
        add(0, OP_R,   0, 1, B_ALUWB,  2'b00, EN_RW,  "r_aluwb");
        add(0, OP_LW,  0, 1, B_FETCH,  2'b00, EN_FCH, "lw_fetch");
        add(0, OP_LW,  0, 1, B_DECODE, 2'b00, EN_0,   "lw_decode");
        add(0, OP_LW,  0, 1, B_MEMADR, 2'b00, EN_0,   "lw_memadr");
        add(0, OP_LW,  0, 1, B_MEMRW,  2'b00, EN_0,   "lw_memread");
        add(0, OP_LW,  0, 1, B_MEMWB,  2'b00, EN_RW,  "lw_memwb");
        add(0, OP_SW,  0, 1, B_FETCH,  2'b01, EN_FCH, "sw_fetch");
        add(0, OP_SW,  0, 1, B_DECODE, 2'b01, EN_0,   "sw_decode");
        add(0, OP_SW,  0, 1, B_MEMADR, 2'b01, EN_0,   "sw_memadr");
        add(0, OP_SW,  0, 0, B_MEMRW,  2'b01, EN_MW,  "sw_stall0");
        add(0, OP_SW,  0, 0, B_MEMRW,  2'b01, EN_MW,  "sw_stall1");
        add(0, OP_SW,  0, 0, B_MEMRW,  2'b01, EN_MW,  "sw_stall2");
        add(0, OP_SW,  0, 1, B_MEMRW,  2'b01, EN_MW,  "sw_done");
        add(0, OP_I,   0, 0, B_FETCH,  2'b00, EN_0,   "fetch_stall0");
        add(0, OP_I,   0, 0, B_FETCH,  2'b00, EN_0,   "fetch_stall1");
        add(0, OP_I,   0, 1, B_FETCH,  2'b00, EN_FCH, "fetch_ready");
        add(0, OP_I,   0, 1, B_DECODE, 2'b00, EN_0,   "i_decode");
        add(0, OP_I,   0, 1, B_EXI,    2'b00, EN_0,   "i_executei");
        add(0, OP_I,   0, 1, B_ALUWB,  2'b00, EN_RW,  "i_aluwb");
        add(0, OP_BEQ, 1, 1, B_FETCH,  2'b10, EN_FCH, "beq1_fetch");
        add(0, OP_BEQ, 1, 1, B_DECODE, 2'b10, EN_0,   "beq1_decode");
        add(0, OP_BEQ, 1, 1, B_BEQ,    2'b10, EN_PC,  "beq1_taken");
        add(0, OP_BEQ, 0, 1, B_FETCH,  2'b10, EN_FCH, "beq0_fetch");
        add(0, OP_BEQ, 0, 1, B_DECODE, 2'b10, EN_0,   "beq0_decode");
        add(0, OP_BEQ, 0, 1, B_BEQ,    2'b10, EN_0,   "beq0_not_taken");
        add(0, OP_JAL, 0, 1, B_FETCH,  2'b11, EN_FCH, "jal_fetch");
        add(0, OP_JAL, 0, 1, B_DECODE, 2'b11, EN_0,   "jal_decode");
        add(0, OP_JAL, 0, 1, B_JAL,    2'b11, EN_PC,  "jal_jump");
        add(0, OP_JAL, 0, 1, B_ALUWB,  2'b11, EN_RW,  "jal_aluwb");
        add(0, OP_BAD, 0, 1, B_FETCH,  2'b00, EN_FCH, "bad_fetch");
        add(0, OP_BAD, 0, 1, B_DECODE, 2'b00, EN_ILL, "bad_decode");
        add(0, OP_SW,  0, 1, B_FETCH,  2'b01, EN_FCH, "after_bad_fetch");

        foreach (vecs[k]) begin
            reset     = vecs[k].rst;
            opcode    = vecs[k].opc;
            zero      = vecs[k].z;
            mem_ready = vecs[k].mr;
            @(negedge clk);
            check(vecs[k].name, {vecs[k].base, vecs[k].imm, vecs[k].en});
            @(posedge clk);
            #1;
        end

        // Store in progress, then reset lands mid-cycle while mem_write is high.
        opcode = OP_SW; mem_ready = 1'b1;
        #1 check("sw2_decode", {B_DECODE, 2'b01, EN_0});
        @(posedge clk); #1;
        check("sw2_memadr", {B_MEMADR, 2'b01, EN_0});
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1 check("sw2_memwrite", {B_MEMRW, 2'b01, EN_MW});
        reset = 1'b1;
        #1 check("async_reset_abort", {B_FETCH, 2'b01, EN_0});
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_reset_fetch", {B_FETCH, 2'b01, EN_FCH});
        @(posedge clk); #1;
        check("post_reset_decode", {B_DECODE, 2'b01, EN_0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main control unit for the RISC-V 32 core. Sequences each instruction through fetch, decode, execute, memory and writeback cycles. Drives the datapath multiplexer selects and write enables, and produces the 2-bit `alu_op` consumed by `alu_decoder`, together with `opcode`, `func3` and `func7`. Sits between the instruction register and the ALU decode/datapath; supports lw, sw, R-type, I-type ALU, beq and jal.

## Interface
- No parameters; all widths fixed for RV32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `opcode`  in  7  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag for beq.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_op`  out  2  00 add, 01 sub, 10 decode by func3/func7.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 RD1.
- `alu_src_b`  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- `result_src`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J.
- `adr_src`  out  1  memory address: 0 PC, 1 Result.
- `ir_write`, `pc_write`, `reg_write`, `mem_write`  out  1 each  write enables.
- `illegal`  out  1  one-cycle pulse when the opcode is unsupported.

## Operation
- 4-bit state register. States:
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMREAD=3
  - MEMWB=4
  - MEMWRITE=5
  - EXECUTER=6
  - EXECUTEI=7
  - ALUWB=8
  - JAL=9
  - BEQ=10
- Codes 11–15 are unreachable; if ever entered, go to FETCH on the next edge.
- Outputs are Moore-type from the state, with three exceptions:
  - `imm_src` is decoded combinationally from `opcode`: 0000011/0010011→00, 0100011→01, 1100011→10, 1101111→11, others→00.
  - `pc_write = pc_update | (branch & zero)`.
  - Enables listed as "gated" are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- Per-state outputs and next state:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update gated. Stay while !mem_ready, else DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precomputes the branch target). Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - anything else → FETCH with `illegal`=1 for that cycle
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready, else MEMWB.
  - MEMWB: result_src=01, reg_write=1 → FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held, not gated). Stay while !mem_ready, else FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 → ALUWB.
  - ALUWB: result_src=00, reg_write=1 → FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 → ALUWB (writes PC+4 to rd).
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 → FETCH.
- `opcode` must be stable from DECODE through the end of the instruction; the IR changes only on `ir_write`.

## Timing
- Reset:
  - Asynchronously forces state to FETCH.
  - While `reset`=1, ir_write, pc_write, reg_write, mem_write and illegal are forced to 0.
  - Other outputs show FETCH values: alu_op=00, alu_src_a=00, alu_src_b=10, result_src=10, adr_src=0.
  - Reset asserted mid-instruction (e.g. in MEMWRITE) aborts immediately; no further write enable is seen.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; outputs hold steady during the stall.
- In FETCH, `pc_write` and `ir_write` assert only in the cycle where `mem_ready`=1, so the PC never double-increments during a stall.
- BEQ: `pc_write`=`zero` in that cycle; `zero`=0 leaves the PC unchanged.

## Test plan
- Reset: assert `reset` in MEMWRITE with mem_write=1 → mem_write drops to 0 asynchronously. On release, state is FETCH with alu_src_b=10.
- Add then load (mem_ready=1): R-type opcode 0110011 → states 0,1,6,8,0 with alu_op=10 in EXECUTER and reg_write only in ALUWB. Then lw 0000011 → states 0,1,2,3,4, with result_src=01 and reg_write=1 in MEMWB.
- Memory stall: sw with mem_ready low for 3 cycles in MEMWRITE → mem_write stays 1 for 4 cycles, then FETCH. Stall FETCH 2 cycles → exactly one pc_write pulse.
- BEQ: zero=1 → pc_write=1, alu_op=01 in BEQ. Repeat with zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- JAL: opcode 1101111 → imm_src=11, pc_write=1 in JAL, then ALUWB with reg_write=1.
- Illegal opcode: opcode 1111111 → illegal=1 for one cycle in DECODE, next state FETCH, and no reg_write or mem_write at any point.
